// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver with 2-of-3 mid-bit majority voting.
// Optional parity bit is compiled in with macro UART_RX_PARITY_EN.
module uart_rx_ovs #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BIT_RATE   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RX,
  output logic                 VALID,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 BREAK,
  output logic                 BUSY
);
  localparam int DIV_RAW = CLK_HZ / (BIT_RATE * OVERSAMPLE);
  localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int DW      = $clog2(DIV + 1);
  localparam int TW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS + 1);
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP, S_WAIT
  } state_t;
  state_t               state;
  logic                 rx_meta, rx_s, rx_prev;
  logic [1:0]           warm;
  logic [DW-1:0]        div_cnt;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [1:0]           smp;
  logic [DATA_BITS-1:0] sh;
  logic                 ferr;
`ifdef UART_RX_PARITY_EN
  logic                 par_err;
`endif
  logic tick, mid, bit_end, vote, fall, last_stop;
  assign tick      = div_cnt == DW'(DIV - 1);
  assign mid       = tick && tick_cnt == TW'(OVERSAMPLE / 2 + 1);
  assign bit_end   = tick && tick_cnt == TW'(OVERSAMPLE - 1);
  assign vote      = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  // warm gates edge detection until the synchroniser holds real line samples
  assign fall      = warm == 2'd3 && rx_prev && !rx_s;
  assign last_stop = bit_cnt == BW'(STOP_BITS - 1);
  assign BUSY      = state != S_IDLE;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      warm       <= '0;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      smp        <= '0;
      sh         <= '0;
      ferr       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err    <= 1'b0;
`endif
      VALID      <= 1'b0;
      DATA       <= '0;
      FRAME_ERR  <= 1'b0;
      PARITY_ERR <= 1'b0;
      BREAK      <= 1'b0;
    end else begin
      rx_meta  <= RX;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      warm     <= warm + 2'(warm != 2'd3);
      VALID    <= 1'b0;
      div_cnt  <= (state == S_IDLE || tick) ? '0 : div_cnt + 1'b1;
      tick_cnt <= state == S_IDLE ? '0 : bit_end ? '0 : tick ? tick_cnt + 1'b1 : tick_cnt;
      if (tick && tick_cnt == TW'(OVERSAMPLE / 2 - 1)) smp[0] <= rx_s;
      if (tick && tick_cnt == TW'(OVERSAMPLE / 2)) smp[1] <= rx_s;
      case (state)
        S_IDLE: if (fall) begin
          state   <= S_START;
          bit_cnt <= '0;
          ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
          par_err <= 1'b0;
`endif
        end
        S_START: begin
          if (mid && vote) state <= S_IDLE;
          else if (bit_end) state <= S_DATA;
        end
        S_DATA: begin
          if (mid) sh <= {vote, sh[DATA_BITS-1:1]};
          if (bit_end) begin
            bit_cnt <= bit_cnt == BW'(DATA_BITS - 1) ? '0 : bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt == BW'(DATA_BITS - 1)) state <= S_PARITY;
`else
            if (bit_cnt == BW'(DATA_BITS - 1)) state <= S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (mid) par_err <= (^sh ^ vote) != (PARITY_ODD != 0);
          if (bit_end) state <= S_STOP;
        end
`endif
        S_STOP: begin
          if (mid && last_stop) begin
            VALID     <= 1'b1;
            DATA      <= sh;
            FRAME_ERR <= ferr | ~vote;
            BREAK     <= sh == '0 && (STOP_BITS == 1 ? !vote : ferr);
`ifdef UART_RX_PARITY_EN
            PARITY_ERR <= par_err;
`endif
            state     <= (ferr || !vote) ? S_WAIT : S_IDLE;
          end else begin
            if (mid) ferr <= ferr | ~vote;
            if (bit_end) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_WAIT: if (rx_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: directed self-checking bench for uart_rx_ovs.
// Line rate 19200 at 12 MHz gives 39 clocks per tick, 624 clocks per bit.
module tb_uart_rx_ovs;
  localparam int BIT = 624;
  logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic       valid, ferr, perr, brk, busy;
  logic [7:0] data;
  int         n_assert = 0, n_fail = 0, vcnt = 0, vlong = 0, v0 = 0;
  logic       v_d = 1'b0;

  uart_rx_ovs #(.CLK_HZ(12_000_000), .BIT_RATE(19200), .DATA_BITS(8), .OVERSAMPLE(16),
                .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .CLK(clk), .RST_N(rst_n), .RX(rx), .VALID(valid), .DATA(data), .FRAME_ERR(ferr),
    .PARITY_ERR(perr), .BREAK(brk), .BUSY(busy));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid && v_d) vlong <= vlong + 1;
    if (valid) vcnt <= vcnt + 1;
    v_d <= valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic stop);
    rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(posedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = p;
    repeat (BIT) @(posedge clk);
`else
    if (p) rx = 1'b0;
`endif
    rx = stop;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic chk_frame(input string tag, input int n, input logic [7:0] d,
                           input logic fe, input logic pe, input logic br);
    @(negedge clk);
    chk({tag, ".valid_cnt"}, vcnt - v0, n);
    chk({tag, ".data"}, data, d);
    chk({tag, ".frame_err"}, ferr, fe);
    chk({tag, ".parity_err"}, perr, pe);
    chk({tag, ".break"}, brk, br);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".valid"}, valid, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".data"}, data, 0);
    chk({tag, ".frame_err"}, ferr, 0);
    chk({tag, ".parity_err"}, perr, 0);
    chk({tag, ".break"}, brk, 0);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    v0 = vcnt;
    send(8'hA5, 1'b0, 1'b1);
    chk_frame("a5", 1, 8'hA5, 0, 0, 0);

    v0 = vcnt;
    send(8'h00, 1'b0, 1'b1);
    chk_frame("b2b_first", 1, 8'h00, 0, 0, 0);
    send(8'hFF, 1'b0, 1'b1);
    chk_frame("b2b_second", 2, 8'hFF, 0, 0, 0);
    repeat (BIT) @(posedge clk);

    v0 = vcnt;
    rx = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("glitch.busy_high", busy, 1);
    repeat (280) @(posedge clk);
    rx = 1'b1;
    repeat (BIT - 300) @(posedge clk);
    @(negedge clk);
    chk("glitch.busy_low", busy, 0);
    chk("glitch.no_valid", vcnt - v0, 0);

    v0 = vcnt;
    rx = 1'b0;
    repeat (24000) @(posedge clk);
    @(negedge clk);
    chk("break.valid_cnt", vcnt - v0, 1);
    chk("break.data", data, 8'h00);
    chk("break.frame_err", ferr, 1);
    chk("break.break", brk, 1);
    chk("break.busy_wait", busy, 1);
    rx = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("break.busy_release", busy, 0);
    chk("break.no_more_valid", vcnt - v0, 1);
    repeat (BIT) @(posedge clk);

`ifdef UART_RX_PARITY_EN
    v0 = vcnt;
    send(8'h07, 1'b0, 1'b1);
    chk_frame("par_bad", 1, 8'h07, 0, 1, 0);
    v0 = vcnt;
    send(8'h07, 1'b1, 1'b1);
    chk_frame("par_good", 1, 8'h07, 0, 0, 0);
`endif

    v0 = vcnt;
    send(8'h3C, 1'b0, 1'b0);
    rx = 1'b1;
    chk_frame("ferr_3c", 1, 8'h3C, 1, 0, 0);
    repeat (BIT) @(posedge clk);

    v0 = vcnt;
    rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h5A >> i) & 8'h01;
      repeat (BIT) @(posedge clk);
    end
    rx = 1'b1;
    repeat (BIT / 2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("midreset");
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    @(negedge clk);
    chk("midreset.no_valid", vcnt - v0, 0);
    chk("midreset.busy", busy, 0);
    v0 = vcnt;
    send(8'h5A, 1'b0, 1'b1);
    chk_frame("after_reset_5a", 1, 8'h5A, 0, 0, 0);

    chk("valid_one_cycle", vlong, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
